bp_lce_req_mshr: RTL and testbench

//  Multi-entry LCE request engine for the FE/BE L1 caches. Accepts cache miss and uncached

---
 rtl/bp_lce_req_mshr.sv | 193 +++++++++++++++++++
 tb/tb_bp_lce_req_mshr.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_lce_req_mshr.sv
// Multi-entry LCE request engine: tracks outstanding cache misses/uncached requests,
// issues LCE->CCE requests and coh_acks, and retires entries on CCE completions.
module bp_lce_req_mshr #(
    parameter int mshr_els_p          = 2,
    parameter int paddr_width_p       = 40,
    parameter int lce_id_width_p      = 4,
    parameter int way_width_p         = 3,
    parameter int block_offset_p      = 6,
    parameter int timeout_max_limit_p = 4,
    parameter int id_width_lp         = (mshr_els_p > 1) ? $clog2(mshr_els_p) : 1
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [lce_id_width_p-1:0] lce_id_i,
    input  logic                      cache_req_v_i,
    output logic                      cache_req_ready_o,
    input  logic [1:0]                cache_req_type_i,
    input  logic [paddr_width_p-1:0]  cache_req_addr_i,
    input  logic [1:0]                cache_req_size_i,
    input  logic [63:0]               cache_req_data_i,
    input  logic                      cache_req_metadata_v_i,
    input  logic [way_width_p-1:0]    cache_req_repl_way_i,
    input  logic                      cache_req_dirty_i,
    output logic                      lce_req_v_o,
    input  logic                      lce_req_ready_i,
    output logic [1:0]                lce_req_type_o,
    output logic [paddr_width_p-1:0]  lce_req_addr_o,
    output logic [id_width_lp-1:0]    lce_req_id_o,
    output logic [way_width_p-1:0]    lce_req_way_o,
    output logic                      lce_req_lru_dirty_o,
    output logic                      lce_req_excl_o,
    output logic [1:0]                lce_req_size_o,
    output logic [63:0]               lce_req_data_o,
    output logic [lce_id_width_p-1:0] lce_req_src_o,
    input  logic                      data_v_i,
    input  logic                      set_tag_v_i,
    input  logic                      wakeup_v_i,
    input  logic                      uc_done_v_i,
    input  logic [id_width_lp-1:0]    cmpl_id_i,
    output logic                      lce_resp_v_o,
    input  logic                      lce_resp_yumi_i,
    output logic [paddr_width_p-1:0]  lce_resp_addr_o,
    output logic [lce_id_width_p-1:0] lce_resp_src_o,
    input  logic                      coherence_blocked_i,
    input  logic                      cmd_ready_i,
    output logic                      idle_o
);
    localparam int cnt_width_lp = $clog2(timeout_max_limit_p + 1);

    typedef enum logic [2:0] {
        e_idle      = 3'd0,
        e_wait_meta = 3'd1,
        e_send      = 3'd2,
        e_sleep     = 3'd3,
        e_ack       = 3'd4
    } state_e;

    state_e                     state_r    [mshr_els_p];
    logic [paddr_width_p-1:0]   addr_r     [mshr_els_p];
    logic [1:0]                 type_r     [mshr_els_p];
    logic [1:0]                 size_r     [mshr_els_p];
    logic [63:0]                pay_data_r [mshr_els_p];
    logic [way_width_p-1:0]     way_r      [mshr_els_p];
    logic                       dirty_r    [mshr_els_p];
    logic                       dflag_r    [mshr_els_p];
    logic                       stflag_r   [mshr_els_p];
    logic [cnt_width_lp-1:0]    tcnt_r;

    logic                       any_idle_s, any_wait_s, conflict_s, all_idle_s;
    logic                       req_found_s, ack_found_s, timeout_s;
    logic [id_width_lp-1:0]     alloc_s, req_sel_s, ack_sel_s;
    logic                       accept_s, req_fire_s, resp_fire_s, uc_rd_s;

    // Scan entries: lowest-index allocation/arbitration, block-address conflicts, idle status.
    always_comb begin
        any_idle_s  = 1'b0;
        any_wait_s  = 1'b0;
        conflict_s  = 1'b0;
        all_idle_s  = 1'b1;
        req_found_s = 1'b0;
        ack_found_s = 1'b0;
        alloc_s     = '0;
        req_sel_s   = '0;
        ack_sel_s   = '0;
        for (int i = 0; i < mshr_els_p; i++) begin
            alloc_s     = (!any_idle_s && state_r[i] == e_idle) ? id_width_lp'(i) : alloc_s;
            any_idle_s  = any_idle_s | (state_r[i] == e_idle);
            any_wait_s  = any_wait_s | (state_r[i] == e_wait_meta);
            all_idle_s  = all_idle_s & (state_r[i] == e_idle);
            conflict_s  = conflict_s | ((state_r[i] != e_idle)
                          && (addr_r[i][paddr_width_p-1:block_offset_p]
                              == cache_req_addr_i[paddr_width_p-1:block_offset_p]));
            req_sel_s   = (!req_found_s && state_r[i] == e_send) ? id_width_lp'(i) : req_sel_s;
            req_found_s = req_found_s | (state_r[i] == e_send);
            ack_sel_s   = (!ack_found_s && state_r[i] == e_ack) ? id_width_lp'(i) : ack_sel_s;
            ack_found_s = ack_found_s | (state_r[i] == e_ack);
        end
    end

    assign timeout_s         = (tcnt_r == cnt_width_lp'(timeout_max_limit_p));
    assign cache_req_ready_o = cmd_ready_i & ~timeout_s & any_idle_s & ~any_wait_s & ~conflict_s;
    assign accept_s          = cache_req_v_i & cache_req_ready_o;
    assign idle_o            = all_idle_s;

    // Uncached loads are issued as an aligned 8-byte read; all fields are zero when nothing is pending.
    assign uc_rd_s             = (type_r[req_sel_s] == 2'd2);
    assign lce_req_v_o         = req_found_s;
    assign req_fire_s          = lce_req_v_o & lce_req_ready_i;
    assign lce_req_type_o      = req_found_s ? type_r[req_sel_s] : 2'd0;
    assign lce_req_addr_o      = !req_found_s ? '0
                               : uc_rd_s ? {addr_r[req_sel_s][paddr_width_p-1:3], 3'b000}
                               : addr_r[req_sel_s];
    assign lce_req_id_o        = req_found_s ? req_sel_s : '0;
    assign lce_req_way_o       = req_found_s ? way_r[req_sel_s] : '0;
    assign lce_req_lru_dirty_o = req_found_s & dirty_r[req_sel_s];
    assign lce_req_excl_o      = req_found_s & (type_r[req_sel_s] == 2'd1);
    assign lce_req_size_o      = !req_found_s ? 2'd0 : uc_rd_s ? 2'd3 : size_r[req_sel_s];
    assign lce_req_data_o      = req_found_s ? pay_data_r[req_sel_s] : 64'd0;
    assign lce_req_src_o       = req_found_s ? lce_id_i : '0;

    assign lce_resp_v_o    = ack_found_s;
    assign resp_fire_s     = lce_resp_v_o & lce_resp_yumi_i;
    assign lce_resp_addr_o = ack_found_s ? addr_r[ack_sel_s] : '0;
    assign lce_resp_src_o  = ack_found_s ? lce_id_i : '0;

    // Coherence-blocked counter; saturates at the limit so ready drops for that cycle.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tcnt_r <= '0;
        end else if (!coherence_blocked_i) begin
            tcnt_r <= '0;
        end else if (!timeout_s) begin
            tcnt_r <= tcnt_r + cnt_width_lp'(1);
        end
    end

    // Per-entry lifecycle FSMs.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < mshr_els_p; i++) begin
                state_r[i]    <= e_idle;
                addr_r[i]     <= '0;
                type_r[i]     <= 2'd0;
                size_r[i]     <= 2'd0;
                pay_data_r[i] <= 64'd0;
                way_r[i]      <= '0;
                dirty_r[i]    <= 1'b0;
                dflag_r[i]    <= 1'b0;
                stflag_r[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < mshr_els_p; i++) begin
                case (state_r[i])
                    e_idle: if (accept_s && alloc_s == id_width_lp'(i)) begin
                        addr_r[i]     <= cache_req_addr_i;
                        type_r[i]     <= cache_req_type_i;
                        size_r[i]     <= cache_req_size_i;
                        pay_data_r[i] <= cache_req_data_i;
                        way_r[i]      <= '0;
                        dirty_r[i]    <= 1'b0;
                        state_r[i]    <= cache_req_type_i[1] ? e_send : e_wait_meta;
                    end
                    e_wait_meta: if (cache_req_metadata_v_i) begin
                        way_r[i]   <= cache_req_repl_way_i;
                        dirty_r[i] <= cache_req_dirty_i;
                        state_r[i] <= e_send;
                    end
                    e_send: if (req_fire_s && req_sel_s == id_width_lp'(i)) begin
                        dflag_r[i]  <= 1'b0;
                        stflag_r[i] <= 1'b0;
                        state_r[i]  <= e_sleep;
                    end
                    e_sleep: if (cmpl_id_i == id_width_lp'(i)) begin
                        if (wakeup_v_i) begin
                            state_r[i] <= e_ack;
                        end else if (uc_done_v_i) begin
                            state_r[i] <= e_idle;
                        end else if ((stflag_r[i] | set_tag_v_i) & (dflag_r[i] | data_v_i)) begin
                            state_r[i] <= e_ack;
                        end else begin
                            dflag_r[i]  <= dflag_r[i] | data_v_i;
                            stflag_r[i] <= stflag_r[i] | set_tag_v_i;
                        end
                    end
                    e_ack: if (resp_fire_s && ack_sel_s == id_width_lp'(i)) begin
                        state_r[i] <= e_idle;
                    end
                    default: state_r[i] <= e_idle;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bp_lce_req_mshr.sv
// Scoreboard bench for bp_lce_req_mshr: directed stimulus pushes expected LCE requests and
// coh_acks; a negedge monitor pops and compares every handshake the DUT presents.
module tb_bp_lce_req_mshr;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  lce_id = 4'hA;
    logic        cache_req_v = 1'b0, cache_req_ready;
    logic [1:0]  cache_req_type = 2'd0, cache_req_size = 2'd0;
    logic [39:0] cache_req_addr = 40'd0;
    logic [63:0] cache_req_data = 64'd0;
    logic        meta_v = 1'b0, meta_dirty = 1'b0;
    logic [2:0]  meta_way = 3'd0;
    logic        lce_req_v, lce_req_ready = 1'b1;
    logic [1:0]  lce_req_type, lce_req_size;
    logic [39:0] lce_req_addr, lce_resp_addr;
    logic        lce_req_id, lce_req_dirty, lce_req_excl;
    logic [2:0]  lce_req_way;
    logic [63:0] lce_req_data;
    logic [3:0]  lce_req_src, lce_resp_src;
    logic        data_v = 1'b0, set_tag_v = 1'b0, wakeup_v = 1'b0, uc_done_v = 1'b0;
    logic        cmpl_id = 1'b0;
    logic        lce_resp_v, lce_resp_yumi, yumi_en = 1'b1;
    logic        coh_blocked = 1'b0, cmd_ready = 1'b1, idle;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [1:0]  typ;
        logic [39:0] addr;
        logic [2:0]  way;
        logic        excl;
        logic        dirty;
        logic [1:0]  size;
        logic [63:0] data;
        logic        id;
        logic [3:0]  src;
    } req_t;
    typedef struct packed {
        logic [39:0] addr;
        logic [3:0]  src;
    } resp_t;

    req_t  req_q[$];
    resp_t resp_q[$];

    assign lce_resp_yumi = lce_resp_v & yumi_en;

    bp_lce_req_mshr dut (
        .clk_i(clk), .reset_n_i(rst_n), .lce_id_i(lce_id),
        .cache_req_v_i(cache_req_v), .cache_req_ready_o(cache_req_ready),
        .cache_req_type_i(cache_req_type), .cache_req_addr_i(cache_req_addr),
        .cache_req_size_i(cache_req_size), .cache_req_data_i(cache_req_data),
        .cache_req_metadata_v_i(meta_v), .cache_req_repl_way_i(meta_way),
        .cache_req_dirty_i(meta_dirty),
        .lce_req_v_o(lce_req_v), .lce_req_ready_i(lce_req_ready),
        .lce_req_type_o(lce_req_type), .lce_req_addr_o(lce_req_addr),
        .lce_req_id_o(lce_req_id), .lce_req_way_o(lce_req_way),
        .lce_req_lru_dirty_o(lce_req_dirty), .lce_req_excl_o(lce_req_excl),
        .lce_req_size_o(lce_req_size), .lce_req_data_o(lce_req_data),
        .lce_req_src_o(lce_req_src),
        .data_v_i(data_v), .set_tag_v_i(set_tag_v), .wakeup_v_i(wakeup_v),
        .uc_done_v_i(uc_done_v), .cmpl_id_i(cmpl_id),
        .lce_resp_v_o(lce_resp_v), .lce_resp_yumi_i(lce_resp_yumi),
        .lce_resp_addr_o(lce_resp_addr), .lce_resp_src_o(lce_resp_src),
        .coherence_blocked_i(coh_blocked), .cmd_ready_i(cmd_ready), .idle_o(idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every request/response handshake must match the head of its queue.
    always @(negedge clk) begin
        if (lce_req_v && lce_req_ready) begin
            if (req_q.size() == 0) begin
                chk("req_unexpected", {lce_req_type, lce_req_addr}, 128'd0);
            end else begin
                chk("lce_req", {lce_req_type, lce_req_addr, lce_req_way, lce_req_excl,
                                lce_req_dirty, lce_req_size, lce_req_data, lce_req_id,
                                lce_req_src}, req_q.pop_front());
            end
        end
        if (lce_resp_v && lce_resp_yumi) begin
            if (resp_q.size() == 0) begin
                chk("resp_unexpected", {lce_resp_addr, lce_resp_src}, 128'd0);
            end else begin
                chk("coh_ack", {lce_resp_addr, lce_resp_src}, resp_q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] typ, input logic [39:0] addr, input logic [1:0] size);
        cache_req_v    = 1'b1;
        cache_req_type = typ;
        cache_req_addr = addr;
        cache_req_size = size;
        cache_req_data = 64'd0;
        #1;
        chk("accept_ready", cache_req_ready, 1'b1);
        tick(1);
        cache_req_v    = 1'b0;
        cache_req_addr = 40'd0;
        #1;
    endtask

    task automatic meta(input logic [2:0] way, input logic dirty);
        meta_v = 1'b1; meta_way = way; meta_dirty = dirty;
        tick(1);
        meta_v = 1'b0;
    endtask

    task automatic cmpl(input logic id, input logic dv, input logic st, input logic wk, input logic ud);
        cmpl_id = id; data_v = dv; set_tag_v = st; wakeup_v = wk; uc_done_v = ud;
        tick(1);
        data_v = 1'b0; set_tag_v = 1'b0; wakeup_v = 1'b0; uc_done_v = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while (!idle && k < 50) begin
            tick(1);
            k++;
        end
        tick(1);
        chk(nm, idle, 1'b1);
    endtask

    initial begin
        tick(2);
        rst_n = 1'b1;
        #1;
        chk("reset_idle", idle, 1'b1);
        chk("reset_req_v", lce_req_v, 1'b0);
        chk("reset_resp_v", lce_resp_v, 1'b0);
        chk("reset_ready", cache_req_ready, 1'b1);

        // miss_load 0x1000 with metadata the next cycle, then data+set_tag
        req_q.push_back({2'd0, 40'h1000, 3'd5, 1'b0, 1'b0, 2'd0, 64'd0, 1'b0, 4'hA});
        issue(2'd0, 40'h1000, 2'd0);
        chk("wait_meta_blocks", cache_req_ready, 1'b0);
        meta(3'd5, 1'b0);
        tick(2);
        resp_q.push_back({40'h1000, 4'hA});
        cmpl(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_idle("miss_retire");

        // uncached load: aligned, size 3, no metadata wait, no coh_ack
        req_q.push_back({2'd2, 40'h2000, 3'd0, 1'b0, 1'b0, 2'd3, 64'd0, 1'b0, 4'hA});
        issue(2'd2, 40'h2004, 2'd1);
        chk("uc_no_meta_wait", cache_req_ready, 1'b1);
        tick(2);
        cmpl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_idle("uc_retire");

        // two misses held back by lce_req_ready=0, out-of-order completion
        lce_req_ready = 1'b0;
        req_q.push_back({2'd0, 40'h1000, 3'd1, 1'b0, 1'b0, 2'd0, 64'd0, 1'b0, 4'hA});
        issue(2'd0, 40'h1000, 2'd0);
        meta(3'd1, 1'b0);
        req_q.push_back({2'd1, 40'h3000, 3'd2, 1'b1, 1'b1, 2'd0, 64'd0, 1'b1, 4'hA});
        issue(2'd1, 40'h3000, 2'd0);
        meta(3'd2, 1'b1);
        chk("held_req_v", lce_req_v, 1'b1);
        chk("held_req_id", lce_req_id, 1'b0);
        cache_req_addr = 40'h8000;
        #1;
        chk("all_busy_ready", cache_req_ready, 1'b0);
        cache_req_addr = 40'd0;
        lce_req_ready = 1'b1;
        tick(3);
        resp_q.push_back({40'h3000, 4'hA});
        cmpl(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(2);
        cmpl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1);
        chk("data_only_no_ack", lce_resp_v, 1'b0);
        resp_q.push_back({40'h1000, 4'hA});
        cmpl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_idle("ooo_retire");

        // same-block conflict while 0x1000 outstanding; wakeup retires via coh_ack
        req_q.push_back({2'd0, 40'h1000, 3'd0, 1'b0, 1'b0, 2'd0, 64'd0, 1'b0, 4'hA});
        issue(2'd0, 40'h1000, 2'd0);
        meta(3'd0, 1'b0);
        tick(2);
        cache_req_addr = 40'h1008;
        #1;
        chk("same_block_blocked", cache_req_ready, 1'b0);
        resp_q.push_back({40'h1000, 4'hA});
        cmpl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_idle("wakeup_retire");
        chk("same_block_released", cache_req_ready, 1'b1);
        cache_req_addr = 40'd0;

        // timeout: blocked for 4 cycles -> ready low only in the fifth
        coh_blocked = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick(1);
            chk("blocked_ready_hi", cache_req_ready, 1'b1);
        end
        tick(1);
        chk("timeout_ready_lo", cache_req_ready, 1'b0);
        coh_blocked = 1'b0;
        tick(1);
        chk("timeout_cleared", cache_req_ready, 1'b1);
        cmd_ready = 1'b0;
        #1;
        chk("cmd_not_ready", cache_req_ready, 1'b0);
        cmd_ready = 1'b1;

        // asynchronous reset mid-SLEEP clears everything, no stale coh_ack
        req_q.push_back({2'd0, 40'h5000, 3'd3, 1'b0, 1'b1, 2'd0, 64'd0, 1'b0, 4'hA});
        issue(2'd0, 40'h5000, 2'd0);
        meta(3'd3, 1'b1);
        tick(2);
        cmpl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_idle", idle, 1'b1);
        chk("rst_req_v", lce_req_v, 1'b0);
        chk("rst_resp_v", lce_resp_v, 1'b0);
        tick(2);
        rst_n = 1'b1;
        cmpl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(2);
        chk("post_rst_no_ack", lce_resp_v, 1'b0);
        chk("post_rst_idle", idle, 1'b1);

        chk("req_q_drained", 128'(req_q.size()), 128'd0);
        chk("resp_q_drained", 128'(resp_q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
